vga_fb_arbiter: RTL and testbench

- Shares one single-port synchronous frame-buffer RAM between two requesters.
  - Display scan-out reads: fixed latency, absolute priority.
  - Host (pattern loader / CPU) reads and writes: valid/ready handshake, served only in slots the display leaves free.
- Sits between the sync/pattern pipeline and the pixel RAM. Lets the host update the frame buffer during blanking without corrupting scan-out.

---
 rtl/vga_fb_arbiter.sv | 164 ++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer port arbiter: display reads have absolute priority, host ops use a 1-entry hold.
// Optional VGA_FB_ARB_STATS_EN adds o_Host_Wait_Max (worst host wait since reset).
module vga_fb_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 6,
  parameter int MAX_WAIT   = 64
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Disp_Req,
  input  logic [ADDR_WIDTH-1:0] i_Disp_Addr,
  output logic [DATA_WIDTH-1:0] o_Disp_Data,
  output logic                  o_Disp_Valid,
  input  logic                  i_Host_Valid,
  input  logic                  i_Host_We,
  input  logic [ADDR_WIDTH-1:0] i_Host_Addr,
  input  logic [DATA_WIDTH-1:0] i_Host_Data,
  output logic                  o_Host_Ready,
  output logic [DATA_WIDTH-1:0] o_Host_Rd_Data,
  output logic                  o_Host_Rd_Valid,
  output logic                  o_Host_Starved,
  output logic                  o_Mem_En,
  output logic                  o_Mem_We,
  output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
  output logic [DATA_WIDTH-1:0] o_Mem_Wr_Data,
  input  logic [DATA_WIDTH-1:0] i_Mem_Rd_Data
`ifdef VGA_FB_ARB_STATS_EN
  ,
  output logic [7:0]            o_Host_Wait_Max
`endif
);

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_DISP,
    TAG_HOST_RD
  } tag_e;

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  logic                  hold_v_q;
  logic                  hold_we_q;
  logic [ADDR_WIDTH-1:0] hold_addr_q;
  logic [DATA_WIDTH-1:0] hold_data_q;
  logic [7:0]            wait_q, wait_d;
  logic                  starved_q;
  tag_e                  tag1_q, tag2_q, tag_d;

  logic                  mem_en_q, mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wd_q;
  logic [DATA_WIDTH-1:0] disp_data_q, host_rd_data_q;
  logic                  disp_valid_q, host_rd_valid_q;

  logic host_issue;
  logic host_ready;
  logic accept;

  always_comb begin
    host_issue = hold_v_q && !i_Disp_Req;
    // Ready is held low during reset so all outputs read 0 while it is asserted.
    host_ready = !i_Reset && (!hold_v_q || host_issue);
    accept     = i_Host_Valid && host_ready;

    wait_d = wait_q;
    if (host_issue) begin
      wait_d = '0;
    end else if (hold_v_q && (wait_q != '1)) begin
      wait_d = wait_q + 8'd1;
    end

    tag_d = TAG_NONE;
    if (i_Disp_Req) begin
      tag_d = TAG_DISP;
    end else if (host_issue && !hold_we_q) begin
      tag_d = TAG_HOST_RD;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      hold_v_q        <= 1'b0;
      hold_we_q       <= 1'b0;
      hold_addr_q     <= '0;
      hold_data_q     <= '0;
      wait_q          <= '0;
      starved_q       <= 1'b0;
      tag1_q          <= TAG_NONE;
      tag2_q          <= TAG_NONE;
      mem_en_q        <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wd_q        <= '0;
      disp_data_q     <= '0;
      disp_valid_q    <= 1'b0;
      host_rd_data_q  <= '0;
      host_rd_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        hold_v_q    <= 1'b1;
        hold_we_q   <= i_Host_We;
        hold_addr_q <= i_Host_Addr;
        hold_data_q <= i_Host_Data;
      end else if (host_issue) begin
        hold_v_q <= 1'b0;
      end

      mem_en_q <= i_Disp_Req || host_issue;
      mem_we_q <= host_issue && hold_we_q;
      if (i_Disp_Req) begin
        mem_addr_q <= i_Disp_Addr;
      end else if (host_issue) begin
        mem_addr_q <= hold_addr_q;
        if (hold_we_q) begin
          mem_wd_q <= hold_data_q;
        end
      end

      // Tag stage 2 lines up with the RAM read data of the op issued two cycles earlier.
      tag1_q <= tag_d;
      tag2_q <= tag1_q;

      disp_valid_q <= (tag2_q == TAG_DISP);
      if (tag2_q == TAG_DISP) begin
        disp_data_q <= i_Mem_Rd_Data;
      end
      host_rd_valid_q <= (tag2_q == TAG_HOST_RD);
      if (tag2_q == TAG_HOST_RD) begin
        host_rd_data_q <= i_Mem_Rd_Data;
      end

      wait_q <= wait_d;
      if (wait_d >= MaxWait) begin
        starved_q <= 1'b1;
      end
    end
  end

`ifdef VGA_FB_ARB_STATS_EN
  logic [7:0] wait_max_q;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      wait_max_q <= '0;
    end else if (host_issue && (wait_q > wait_max_q)) begin
      wait_max_q <= wait_q;
    end
  end

  assign o_Host_Wait_Max = wait_max_q;
`endif

  assign o_Host_Ready    = host_ready;
  assign o_Host_Starved  = starved_q;
  assign o_Mem_En        = mem_en_q;
  assign o_Mem_We        = mem_we_q;
  assign o_Mem_Addr      = mem_addr_q;
  assign o_Mem_Wr_Data   = mem_wd_q;
  assign o_Disp_Data     = disp_data_q;
  assign o_Disp_Valid    = disp_valid_q;
  assign o_Host_Rd_Data  = host_rd_data_q;
  assign o_Host_Rd_Valid = host_rd_valid_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized bench for vga_fb_arbiter against a transaction-level model with a behavioural RAM.
// Define VGA_FB_ARB_STATS_EN to also check o_Host_Wait_Max.
module tb_vga_fb_arbiter;

  localparam int AW = 12;
  localparam int DW = 6;
  localparam int MW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          host_valid = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_data = '0;
  logic          host_ready;
  logic [DW-1:0] host_rd_data;
  logic          host_rd_valid;
  logic          host_starved;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] ram_rd = '0;
`ifdef VGA_FB_ARB_STATS_EN
  logic [7:0]    wait_max;
`endif

  always #5 clk = ~clk;

  vga_fb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .i_Clk          (clk),
    .i_Reset        (rst),
    .i_Disp_Req     (disp_req),
    .i_Disp_Addr    (disp_addr),
    .o_Disp_Data    (disp_data),
    .o_Disp_Valid   (disp_valid),
    .i_Host_Valid   (host_valid),
    .i_Host_We      (host_we),
    .i_Host_Addr    (host_addr),
    .i_Host_Data    (host_data),
    .o_Host_Ready   (host_ready),
    .o_Host_Rd_Data (host_rd_data),
    .o_Host_Rd_Valid(host_rd_valid),
    .o_Host_Starved (host_starved),
    .o_Mem_En       (mem_en),
    .o_Mem_We       (mem_we),
    .o_Mem_Addr     (mem_addr),
    .o_Mem_Wr_Data  (mem_wd),
    .i_Mem_Rd_Data  (ram_rd)
`ifdef VGA_FB_ARB_STATS_EN
    ,
    .o_Host_Wait_Max(wait_max)
`endif
  );

  // Single-port synchronous RAM seen by the arbiter.
  logic [DW-1:0] ram [1<<AW];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wd;
      else        ram_rd <= ram[mem_addr];
    end
  end

  // Reference model: RAM contents as of each grant, results scheduled 3 cycles out.
  logic [DW-1:0] mram [1<<AW];
  bit            sv_d[8], sv_h[8];
  logic [DW-1:0] sd_d[8], sd_h[8];
  bit            h_v, h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_data;
  int unsigned   m_wait, m_wmax;
  bit            m_starved;
  bit            e_en, e_we, e_dv, e_hv;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd, e_dd, e_hd;
  bit            pend;
  int unsigned   cyc;
  int            errors = 0;
  int            checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      sv_d[i] = 1'b0; sv_h[i] = 1'b0; sd_d[i] = '0; sd_h[i] = '0;
    end
    h_v = 1'b0; h_we = 1'b0; h_addr = '0; h_data = '0;
    m_wait = 0; m_wmax = 0; m_starved = 1'b0;
    e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
    e_dv = 1'b0; e_hv = 1'b0; e_dd = '0; e_hd = '0;
    pend = 1'b0;
  endtask

  task automatic step(input bit r, input bit d, input logic [AW-1:0] da,
                      input bit want, input bit we, input logic [AW-1:0] ha,
                      input logic [DW-1:0] hd);
    bit rdy;
    int unsigned s, f;
    @(negedge clk);
    rst       = r;
    disp_req  = d;
    disp_addr = da;
    if (!pend) begin
      host_valid = want; host_we = we; host_addr = ha; host_data = hd;
    end
    #1;
    s = cyc % 8;
    f = (cyc + 3) % 8;
    e_dv = sv_d[s]; if (e_dv) e_dd = sd_d[s]; sv_d[s] = 1'b0;
    e_hv = sv_h[s]; if (e_hv) e_hd = sd_h[s]; sv_h[s] = 1'b0;
    rdy = !r && (!h_v || !d);

    check_eq("host_ready",   host_ready,    rdy);
    check_eq("disp_valid",   disp_valid,    e_dv);
    check_eq("disp_data",    disp_data,     e_dd);
    check_eq("host_rd_vld",  host_rd_valid, e_hv);
    check_eq("host_rd_data", host_rd_data,  e_hd);
    check_eq("mem_en",       mem_en,        e_en);
    check_eq("mem_we",       mem_we,        e_we);
    check_eq("mem_addr",     mem_addr,      e_addr);
    check_eq("mem_wr_data",  mem_wd,        e_wd);
    check_eq("starved",      host_starved,  m_starved);
`ifdef VGA_FB_ARB_STATS_EN
    check_eq("wait_max",     wait_max,      m_wmax);
`endif

    if (r) begin
      model_reset();
    end else begin
      if (d) begin
        sv_d[f] = 1'b1; sd_d[f] = mram[da];
        e_en = 1'b1; e_we = 1'b0; e_addr = da;
      end else if (h_v) begin
        e_en = 1'b1; e_we = h_we; e_addr = h_addr;
        if (h_we) begin
          e_wd = h_data; mram[h_addr] = h_data;
        end else begin
          sv_h[f] = 1'b1; sd_h[f] = mram[h_addr];
        end
        if (m_wait > m_wmax) m_wmax = m_wait;
        m_wait = 0;
      end else begin
        e_en = 1'b0; e_we = 1'b0;
      end
      if (h_v && d) begin
        if (m_wait < 255) m_wait++;
        if (m_wait >= MW) m_starved = 1'b1;
      end
      if (host_valid && rdy) begin
        h_v = 1'b1; h_we = host_we; h_addr = host_addr; h_data = host_data;
      end else if (h_v && !d) begin
        h_v = 1'b0;
      end
      pend = host_valid && !rdy;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, '0, '0);
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) begin
      ram[a]  = 6'(a);
      mram[a] = 6'(a);
    end
    cyc = 0;
    model_reset();
    repeat (3) @(posedge clk);

    // Display-only burst over addresses 0..7.
    for (int i = 0; i < 8; i++) step(0, 1, 12'(i), 0, 0, '0, '0);
    idle(4);

    // Host write then read-back with no display traffic.
    step(0, 0, '0, 1, 1, 12'h010, 6'h2A);
    idle(3);
    step(0, 0, '0, 1, 0, 12'h010, '0);
    idle(5);

    // Host write accepted while display holds the port for 9 cycles.
    for (int i = 0; i < 9; i++) step(0, 1, 12'(12'h100 + i), (i == 0), 1, 12'h020, 6'h15);
    idle(4);

    // Starvation: held host read behind 20 display cycles.
    step(0, 0, '0, 1, 0, 12'h030, '0);
    for (int i = 0; i < 20; i++) step(0, 1, 12'(12'h200 + i), 0, 0, '0, '0);
    idle(5);
    check_eq("starved_sticky", host_starved, 1);
`ifdef VGA_FB_ARB_STATS_EN
    check_eq("wait_max_20", wait_max, 20);
`endif

    // Reset right after a host read and a display read are issued.
    step(0, 0, '0, 1, 0, 12'h040, '0);
    step(0, 0, '0, 0, 0, '0, '0);
    step(0, 1, 12'h050, 0, 0, '0, '0);
    step(1, 0, '0, 0, 0, '0, '0);
    idle(6);

    // Back-to-back host writes.
    for (int i = 0; i < 16; i++) step(0, 0, '0, 1, 1, 12'(12'h300 + i), 6'(i * 3));
    idle(4);

    // Random mixed traffic on a small address window to provoke read-after-write hazards.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < 55),
           12'($urandom_range(0, 15)), ($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)),
           6'($urandom_range(0, 63)));
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
